// File: rtl/gs_pkg.sv
// -----------------------------------------------------------------------------
// gs_pkg
// Constants and types shared by the graphics pipeline blocks. The viewport
// clipper and the line rasterizer both use these.
//   XMAX / YMAX : last valid screen column / row of the 800x480 screen
//   coord_t     : signed screen coordinate
//   state_t     : line rasterizer sequencing states
// -----------------------------------------------------------------------------
package gs_pkg;

    localparam int XMAX = 799;
    localparam int YMAX = 479;

    typedef logic signed [15:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/line_raster_if.sv
// -----------------------------------------------------------------------------
// line_raster_if
// Groups the segment input handshake and the pixel output handshake of
// line_raster.
//   i_valid / o_ready           : segment offered / block can accept a segment
//   i_x1, i_y1, i_x2, i_y2      : signed segment endpoints
//   o_px_valid / i_px_ready     : pixel valid / downstream accepts pixel
//   o_px_x, o_px_y              : signed pixel coordinate
//   o_px_last                   : final (endpoint-2) pixel of the segment
// Modports: slave = rasterizer side, master = segment source / pixel sink.
// -----------------------------------------------------------------------------
interface line_raster_if #(
    parameter int COORD_W = 16
);

    logic                      i_valid;
    logic                      o_ready;
    logic signed [COORD_W-1:0] i_x1;
    logic signed [COORD_W-1:0] i_y1;
    logic signed [COORD_W-1:0] i_x2;
    logic signed [COORD_W-1:0] i_y2;
    logic                      o_px_valid;
    logic                      i_px_ready;
    logic signed [COORD_W-1:0] o_px_x;
    logic signed [COORD_W-1:0] o_px_y;
    logic                      o_px_last;

    modport slave (
        input  i_valid,
        input  i_x1,
        input  i_y1,
        input  i_x2,
        input  i_y2,
        input  i_px_ready,
        output o_ready,
        output o_px_valid,
        output o_px_x,
        output o_px_y,
        output o_px_last
    );

    modport master (
        output i_valid,
        output i_x1,
        output i_y1,
        output i_x2,
        output i_y2,
        output i_px_ready,
        input  o_ready,
        input  o_px_valid,
        input  o_px_x,
        input  o_px_y,
        input  o_px_last
    );

endinterface

// File: rtl/line_raster_step.sv
// -----------------------------------------------------------------------------
// line_raster_step
// Combinational Bresenham step. Given the current error term, the deltas,
// the step directions and the current point, it returns the error term and
// point of the next pixel. Both axis decisions use the incoming error term,
// so a diagonal step updates both axes at once.
//   i_err           : current error term (COORD_W+2 bits, signed)
//   i_dx, i_dy      : |x2-x1| and -|y2-y1| (COORD_W+1 bits, signed)
//   i_sx_neg/sy_neg : 1 when the axis steps towards smaller coordinates
//   i_cur_x/y       : current pixel
//   o_err, o_x, o_y : values for the next pixel
// -----------------------------------------------------------------------------
module line_raster_step
    import gs_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic signed [COORD_W+1:0] i_err,
    input  logic signed [COORD_W:0]   i_dx,
    input  logic signed [COORD_W:0]   i_dy,
    input  logic                      i_sx_neg,
    input  logic                      i_sy_neg,
    input  logic signed [COORD_W-1:0] i_cur_x,
    input  logic signed [COORD_W-1:0] i_cur_y,
    output logic signed [COORD_W+1:0] o_err,
    output logic signed [COORD_W-1:0] o_x,
    output logic signed [COORD_W-1:0] o_y
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_w;
    logic signed [COORD_W+2:0] dy_w;
    logic                      step_x;
    logic                      step_y;

    always_comb begin
        e2     = {i_err, 1'b0};
        dx_w   = {{2{i_dx[COORD_W]}}, i_dx};
        dy_w   = {{2{i_dy[COORD_W]}}, i_dy};
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);

        o_err = i_err;
        o_x   = i_cur_x;
        o_y   = i_cur_y;

        if (step_x) begin
            o_err = o_err + {i_dy[COORD_W], i_dy};
            o_x   = i_sx_neg ? (i_cur_x - COORD_W'(1)) : (i_cur_x + COORD_W'(1));
        end
        if (step_y) begin
            o_err = o_err + {i_dx[COORD_W], i_dx};
            o_y   = i_sy_neg ? (i_cur_y - COORD_W'(1)) : (i_cur_y + COORD_W'(1));
        end
    end

endmodule

// File: rtl/line_raster.sv
// -----------------------------------------------------------------------------
// line_raster
// Bresenham line rasterizer. Accepts one clipped segment (x1,y1)-(x2,y2) per
// handshake and emits its pixels from endpoint 1 to endpoint 2, one per clock
// while the pixel sink is ready.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : line_raster_if.slave (segment in, pixel out handshakes)
//   o_busy     : a segment is in SETUP or RUN
//   o_guard_err: (LINE_RASTER_GUARD_EN only) sticky off-screen pixel flag
// Optional build macro LINE_RASTER_GUARD_EN: off-screen pixels are stepped
// over without being presented, and o_guard_err records that it happened.
// -----------------------------------------------------------------------------
module line_raster #(
    parameter int COORD_W = 16
`ifdef LINE_RASTER_GUARD_EN
    ,
    parameter int XMAX = gs_pkg::XMAX,
    parameter int YMAX = gs_pkg::YMAX
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    line_raster_if.slave     bus,
    output logic             o_busy
`ifdef LINE_RASTER_GUARD_EN
    ,
    output logic             o_guard_err
`endif
);

    localparam int DW = COORD_W + 1;
    localparam int EW = COORD_W + 2;

    gs_pkg::state_t state_q, state_d;

    logic signed [COORD_W-1:0] x1_q, x1_d;
    logic signed [COORD_W-1:0] y1_q, y1_d;
    logic signed [COORD_W-1:0] x2_q, x2_d;
    logic signed [COORD_W-1:0] y2_q, y2_d;
    logic signed [COORD_W-1:0] cur_x_q, cur_x_d;
    logic signed [COORD_W-1:0] cur_y_q, cur_y_d;
    logic signed [DW-1:0]      dx_q, dx_d;
    logic signed [DW-1:0]      dy_q, dy_d;
    logic                      sx_neg_q, sx_neg_d;
    logic                      sy_neg_q, sy_neg_d;
    logic signed [EW-1:0]      err_q, err_d;

    // Setup arithmetic on the latched endpoints
    logic signed [DW-1:0]      diff_x;
    logic signed [DW-1:0]      diff_y;
    logic signed [DW-1:0]      abs_dx;
    logic signed [DW-1:0]      neg_ady;
    logic signed [EW-1:0]      err_setup;

    // Stepper results
    logic signed [EW-1:0]      err_step;
    logic signed [COORD_W-1:0] x_step;
    logic signed [COORD_W-1:0] y_step;

    logic run_pix;
    logic at_end;
    logic in_range;
    logic pix_show;
    logic advance;

`ifdef LINE_RASTER_GUARD_EN
    localparam logic signed [COORD_W-1:0] XMAX_C = COORD_W'(XMAX);
    localparam logic signed [COORD_W-1:0] YMAX_C = COORD_W'(YMAX);

    logic guard_err_q, guard_err_d;
`endif

    always_comb begin
        diff_x    = {x2_q[COORD_W-1], x2_q} - {x1_q[COORD_W-1], x1_q};
        diff_y    = {y2_q[COORD_W-1], y2_q} - {y1_q[COORD_W-1], y1_q};
        abs_dx    = diff_x[DW-1] ? -diff_x : diff_x;
        neg_ady   = diff_y[DW-1] ? diff_y : -diff_y;
        err_setup = {abs_dx[DW-1], abs_dx} + {neg_ady[DW-1], neg_ady};
    end

    line_raster_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_err    (err_q),
        .i_dx     (dx_q),
        .i_dy     (dy_q),
        .i_sx_neg (sx_neg_q),
        .i_sy_neg (sy_neg_q),
        .i_cur_x  (cur_x_q),
        .i_cur_y  (cur_y_q),
        .o_err    (err_step),
        .o_x      (x_step),
        .o_y      (y_step)
    );

    always_comb begin
        run_pix = (state_q == gs_pkg::RUN);
        at_end  = (cur_x_q == x2_q) && (cur_y_q == y2_q);
`ifdef LINE_RASTER_GUARD_EN
        in_range = !cur_x_q[COORD_W-1] && (cur_x_q <= XMAX_C) &&
                   !cur_y_q[COORD_W-1] && (cur_y_q <= YMAX_C);
`else
        in_range = 1'b1;
`endif
        pix_show = run_pix && in_range;
        // A suppressed pixel is consumed internally, so it never waits for
        // the sink.
        advance  = run_pix && (bus.i_px_ready || !in_range);
    end

    always_comb begin
        state_d  = state_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
`ifdef LINE_RASTER_GUARD_EN
        guard_err_d = guard_err_q;
        if (run_pix && !in_range) begin
            guard_err_d = 1'b1;
        end
`endif

        unique case (state_q)
            gs_pkg::IDLE: begin
                if (bus.i_valid) begin
                    x1_d    = bus.i_x1;
                    y1_d    = bus.i_y1;
                    x2_d    = bus.i_x2;
                    y2_d    = bus.i_y2;
                    state_d = gs_pkg::SETUP;
                end
            end
            gs_pkg::SETUP: begin
                dx_d     = abs_dx;
                dy_d     = neg_ady;
                sx_neg_d = !(x1_q < x2_q);
                sy_neg_d = !(y1_q < y2_q);
                err_d    = err_setup;
                cur_x_d  = x1_q;
                cur_y_d  = y1_q;
                state_d  = gs_pkg::RUN;
            end
            gs_pkg::RUN: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = gs_pkg::IDLE;
                    end else begin
                        err_d   = err_step;
                        cur_x_d = x_step;
                        cur_y_d = y_step;
                    end
                end
            end
            default: begin
                state_d = gs_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= gs_pkg::IDLE;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

`ifdef LINE_RASTER_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_err_q <= 1'b0;
        end else begin
            guard_err_q <= guard_err_d;
        end
    end

    assign o_guard_err = guard_err_q;
`endif

    assign bus.o_ready    = (state_q == gs_pkg::IDLE);
    assign bus.o_px_valid = pix_show;
    assign bus.o_px_x     = cur_x_q;
    assign bus.o_px_y     = cur_y_q;
    assign bus.o_px_last  = pix_show && at_end;
    assign o_busy         = (state_q != gs_pkg::IDLE);

endmodule

// File: tb/tb_line_raster.sv
// -----------------------------------------------------------------------------
// tb_line_raster
// Directed bench for line_raster. Expected pixel streams come from an integer
// model of the line-drawing rules; the model itself is pinned against
// hand-written pixel lists. A monitor checks every accepted pixel, stall
// stability and the return of o_ready after the last pixel.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_line_raster;

    logic clk;
    logic rst_n;
    logic busy;
`ifdef LINE_RASTER_GUARD_EN
    logic guard_err;
`endif

    line_raster_if #(.COORD_W(16)) bus ();

    line_raster #(
        .COORD_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_busy      (busy)
`ifdef LINE_RASTER_GUARD_EN
        ,
        .o_guard_err (guard_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   stall_left = 0;
    bit   stall_arm  = 0;
    int   stall_x    = 0;
    int   stall_seen = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Integer model of the line rules; appends the pixels the sink must see.
    function automatic void model_fill(input int x1, input int y1,
                                       input int x2, input int y2);
        int  dx, dy, sx, sy, err, e2, x, y;
        bit  fin, show;
        dx  = iabs(x2 - x1);
        dy  = -iabs(y2 - y1);
        sx  = (x1 < x2) ? 1 : -1;
        sy  = (y1 < y2) ? 1 : -1;
        err = dx + dy;
        x   = x1;
        y   = y1;
        for (int n = 0; n < 100000; n++) begin
            fin  = (x == x2) && (y == y2);
`ifdef LINE_RASTER_GUARD_EN
            show = (x >= 0) && (x <= 799) && (y >= 0) && (y <= 479);
`else
            show = 1'b1;
`endif
            if (show) exp_q.push_back('{x: x, y: y, last: fin});
            if (fin) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic pin_list(input string nm, input int xs[$], input int ys[$]);
        check({nm, "_count"}, exp_q.size(), xs.size());
        for (int i = 0; i < xs.size() && i < exp_q.size(); i++) begin
            check({nm, "_x"}, exp_q[i].x, xs[i]);
            check({nm, "_y"}, exp_q[i].y, ys[i]);
            check({nm, "_last"}, int'(exp_q[i].last), (i == xs.size() - 1) ? 1 : 0);
        end
    endtask

    // Pixel sink ready: high except during a programmed 3-cycle stall.
    initial begin
        bus.i_px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.i_px_ready = 1'b0;
                stall_left--;
            end else if (stall_arm && bus.o_px_valid && (int'(bus.o_px_x) == stall_x)) begin
                bus.i_px_ready = 1'b0;
                stall_left     = 2;
                stall_arm      = 1'b0;
            end else begin
                bus.i_px_ready = 1'b1;
            end
        end
    end

    // Monitor: every accepted pixel against the expected stream.
    initial begin
        bit   stall_prev = 0;
        bit   last_acc   = 0;
        int   held_x = 0, held_y = 0;
        pix_t p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (last_acc) begin
                    check("ready_after_last", int'(bus.o_ready), 1);
                    last_acc = 0;
                end
                if (stall_prev) begin
                    check("stall_hold_valid", int'(bus.o_px_valid), 1);
                    check("stall_hold_x", int'(bus.o_px_x), held_x);
                    check("stall_hold_y", int'(bus.o_px_y), held_y);
                end
                if (bus.o_px_valid && !bus.i_px_ready) stall_seen++;
                if (bus.o_px_valid && bus.i_px_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_pixel: got (%0d,%0d), expected no pixel",
                                 bus.o_px_x, bus.o_px_y);
                    end else begin
                        p = exp_q.pop_front();
                        check("px_x", int'(bus.o_px_x), p.x);
                        check("px_y", int'(bus.o_px_y), p.y);
                        check("px_last", int'(bus.o_px_last), int'(p.last));
                    end
                    if (bus.o_px_last) last_acc = 1;
                end
                stall_prev = bus.o_px_valid && !bus.i_px_ready;
                held_x     = int'(bus.o_px_x);
                held_y     = int'(bus.o_px_y);
            end else begin
                stall_prev = 0;
                last_acc   = 0;
            end
        end
    end

    task automatic offer_and_accept(input int x1, input int y1, input int x2, input int y2);
        int n;
        @(posedge clk);
        #1;
        bus.i_x1    = 16'(x1);
        bus.i_y1    = 16'(y1);
        bus.i_x2    = 16'(x2);
        bus.i_y2    = 16'(y2);
        bus.i_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_ready && n < 50);
        check("accept_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic run_seg(input int x1, input int y1, input int x2, input int y2,
                           input bit first_shown);
        int n;
        if (exp_q.size() == 0) model_fill(x1, y1, x2, y2);
        offer_and_accept(x1, y1, x2, y2);
        @(negedge clk);
        check("setup_no_pixel", int'(bus.o_px_valid), 0);
        check("setup_busy", int'(busy), 1);
        check("setup_not_ready", int'(bus.o_ready), 0);
        @(negedge clk);
        check("first_pixel_latency", int'(bus.o_px_valid), first_shown ? 1 : 0);
        n = 0;
        while (!bus.o_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("seg_done", int'(bus.o_ready), 1);
        check("seg_idle_busy", int'(busy), 0);
        check("seg_pixels_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int xs[$];
        int ys[$];
        int n;

        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_x1    = '0;
        bus.i_y1    = '0;
        bus.i_x2    = '0;
        bus.i_y2    = '0;

        #1;
        check("rst_ready", int'(bus.o_ready), 1);
        check("rst_valid", int'(bus.o_px_valid), 0);
        check("rst_x", int'(bus.o_px_x), 0);
        check("rst_y", int'(bus.o_px_y), 0);
        check("rst_last", int'(bus.o_px_last), 0);
        check("rst_busy", int'(busy), 0);
`ifdef LINE_RASTER_GUARD_EN
        check("rst_guard_err", int'(guard_err), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Horizontal
        model_fill(0, 0, 3, 0);
        xs = {0, 1, 2, 3}; ys = {0, 0, 0, 0};
        pin_list("pin_horiz", xs, ys);
        run_seg(0, 0, 3, 0, 1);

        // Steep
        model_fill(0, 0, 1, 3);
        xs = {0, 0, 1, 1}; ys = {0, 1, 2, 3};
        pin_list("pin_steep", xs, ys);
        run_seg(0, 0, 1, 3, 1);

        // Reversed diagonal
        model_fill(5, 5, 2, 2);
        xs = {5, 4, 3, 2}; ys = {5, 4, 3, 2};
        pin_list("pin_revdiag", xs, ys);
        run_seg(5, 5, 2, 2, 1);

        // Single point followed straight away by another segment
        model_fill(7, 9, 7, 9);
        xs = {7}; ys = {9};
        pin_list("pin_point", xs, ys);
        run_seg(7, 9, 7, 9, 1);
        run_seg(10, 20, 13, 22, 1);

        // Backpressure: 3 stalled cycles on pixel (1,0)
        stall_seen = 0;
        stall_x    = 1;
        stall_arm  = 1'b1;
        run_seg(0, 0, 3, 0, 1);
        check("stall_cycles", stall_seen, 3);

        // More shapes, model only
        run_seg(3, 10, 0, 0, 1);
        run_seg(100, 200, 110, 195, 1);
        model_fill(799, 479, 0, 0);
        check("long_count", exp_q.size(), 800);
        run_seg(799, 479, 0, 0, 1);

        // Reset while the third pixel of (0,0)-(9,0) is on the port
        model_fill(0, 0, 9, 0);
        offer_and_accept(0, 0, 9, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.o_px_valid && int'(bus.o_px_x) == 2) && n < 50);
        check("mid_reached_px2", int'(bus.o_px_x), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(bus.o_ready), 1);
        check("midrst_valid", int'(bus.o_px_valid), 0);
        check("midrst_x", int'(bus.o_px_x), 0);
        check("midrst_y", int'(bus.o_px_y), 0);
        check("midrst_last", int'(bus.o_px_last), 0);
        check("midrst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_hold_valid", int'(bus.o_px_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        model_fill(0, 0, 1, 0);
        check("after_rst_count", exp_q.size(), 2);
        run_seg(0, 0, 1, 0, 1);

`ifdef LINE_RASTER_GUARD_EN
        // Off-screen tail is stepped over silently
        check("guard_err_clear", int'(guard_err), 0);
        model_fill(798, 0, 801, 0);
        xs = {798, 799}; ys = {0, 0};
        check("pin_guard_count", exp_q.size(), 2);
        for (int i = 0; i < exp_q.size() && i < 2; i++) begin
            check("pin_guard_x", exp_q[i].x, xs[i]);
            check("pin_guard_last", int'(exp_q[i].last), 0);
        end
        run_seg(798, 0, 801, 0, 1);
        check("guard_err_set", int'(guard_err), 1);
        run_seg(0, 0, 2, 0, 1);
        check("guard_err_sticky", int'(guard_err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
